// File: rtl/irb_pkg.sv
// Shared types for the inverted-residual-block tile sequencer.
package irb_pkg;

    // Sequencer states; one DMA, start or wait state per pipeline step.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LD_W   = 4'd1,
        S_LD_FMI = 4'd2,
        S_EXP_S  = 4'd3,
        S_EXP_W  = 4'd4,
        S_DW_S   = 4'd5,
        S_DW_W   = 4'd6,
        S_PRJ_S  = 4'd7,
        S_PRJ_W  = 4'd8,
        S_ST_FMO = 4'd9,
        S_NEXT   = 4'd10,
        S_DONE   = 4'd11,
        S_ERROR  = 4'd12
    } irb_seq_state_t;

    // DMA operation selector; DMA_LD_W is the idle/reset encoding.
    typedef enum logic [1:0] {
        DMA_LD_W   = 2'd0,
        DMA_LD_FMI = 2'd1,
        DMA_ST_FMO = 2'd2
    } dma_op_t;

    // States that wait on an external responder and are guarded by the watchdog.
    function automatic logic is_guarded(irb_seq_state_t s);
        return (s == S_LD_W)  || (s == S_LD_FMI) || (s == S_ST_FMO) ||
               (s == S_EXP_W) || (s == S_DW_W)   || (s == S_PRJ_W);
    endfunction

endpackage

// File: rtl/irb_watchdog.sv
// Per-wait watchdog: counts enabled cycles since the last clear, saturating at all-ones.
module irb_watchdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Clear wins over counting so a new state always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_enable && (r_cnt == '1);

endmodule

// File: rtl/irb_tile_sequencer.sv
// Layer-level controller: loads weights once, then per tile runs
// LD_FMI -> EXP -> DW -> PRJ -> ST_FMO, walking tiles x-inner.
module irb_tile_sequencer
    import irb_pkg::*;
#(
    parameter int TILE_W    = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] cfg_ntx,
    input  logic [TILE_W-1:0] cfg_nty,
    output logic              dma_req,
    output logic [1:0]        dma_op,
    input  logic              dma_done,
    output logic              exp_start,
    input  logic              exp_finish,
    output logic              dw_start,
    input  logic              dw_finish,
    output logic              prj_start,
    input  logic              prj_finish,
    output logic [TILE_W-1:0] tile_x,
    output logic [TILE_W-1:0] tile_y,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [TILE_W-1:0] ONE = TILE_W'(1);

    irb_seq_state_t    r_state, w_state_nxt;
    logic [TILE_W-1:0] r_tile_x, w_tile_x_nxt;
    logic [TILE_W-1:0] r_tile_y, w_tile_y_nxt;
    logic [TILE_W-1:0] r_ntx, w_ntx_nxt;
    logic [TILE_W-1:0] r_nty, w_nty_nxt;
    logic              r_err, w_err_nxt;

    logic              w_last_x, w_last_y;
    logic              w_wd_en, w_wd_clear, w_wd_exp;
    dma_op_t           w_dma_op;

    assign w_last_x   = (r_tile_x == (r_ntx - ONE));
    assign w_last_y   = (r_tile_y == (r_nty - ONE));
    assign w_wd_en    = is_guarded(r_state);
    assign w_wd_clear = (w_state_nxt != r_state);

    irb_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wd (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_en),
        .o_expired (w_wd_exp)
    );

    // State, tile counters, latched config and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_tile_x <= '0;
            r_tile_y <= '0;
            r_ntx    <= '0;
            r_nty    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tile_x <= w_tile_x_nxt;
            r_tile_y <= w_tile_y_nxt;
            r_ntx    <= w_ntx_nxt;
            r_nty    <= w_nty_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Next-state logic; a responder pulse outside its own wait state is simply not looked at.
    always_comb begin
        w_state_nxt  = r_state;
        w_tile_x_nxt = r_tile_x;
        w_tile_y_nxt = r_tile_y;
        w_ntx_nxt    = r_ntx;
        w_nty_nxt    = r_nty;
        w_err_nxt    = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    // A zero tile count would never terminate; run it as one tile.
                    w_ntx_nxt    = (cfg_ntx == '0) ? ONE : cfg_ntx;
                    w_nty_nxt    = (cfg_nty == '0) ? ONE : cfg_nty;
                    w_tile_x_nxt = '0;
                    w_tile_y_nxt = '0;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = S_LD_W;
                end
            end
            S_LD_W:   if (dma_done)   w_state_nxt = S_LD_FMI;
            S_LD_FMI: if (dma_done)   w_state_nxt = S_EXP_S;
            S_EXP_S:                  w_state_nxt = S_EXP_W;
            S_EXP_W:  if (exp_finish) w_state_nxt = S_DW_S;
            S_DW_S:                   w_state_nxt = S_DW_W;
            S_DW_W:   if (dw_finish)  w_state_nxt = S_PRJ_S;
            S_PRJ_S:                  w_state_nxt = S_PRJ_W;
            S_PRJ_W:  if (prj_finish) w_state_nxt = S_ST_FMO;
            S_ST_FMO: if (dma_done)   w_state_nxt = S_NEXT;
            S_NEXT: begin
                if (w_last_x && w_last_y) begin
                    w_state_nxt = S_DONE;
                end else if (w_last_x) begin
                    w_tile_x_nxt = '0;
                    w_tile_y_nxt = r_tile_y + ONE;
                    w_state_nxt  = S_LD_FMI;
                end else begin
                    w_tile_x_nxt = r_tile_x + ONE;
                    w_state_nxt  = S_LD_FMI;
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            S_ERROR:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        // A response arriving on the expiry cycle still wins; otherwise abort.
        if (w_wd_exp && (w_state_nxt == r_state)) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 1'b1;
        end
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        dma_req   = 1'b0;
        w_dma_op  = DMA_LD_W;
        exp_start = 1'b0;
        dw_start  = 1'b0;
        prj_start = 1'b0;
        unique case (r_state)
            S_LD_W:   begin dma_req = 1'b1; w_dma_op = DMA_LD_W;   end
            S_LD_FMI: begin dma_req = 1'b1; w_dma_op = DMA_LD_FMI; end
            S_ST_FMO: begin dma_req = 1'b1; w_dma_op = DMA_ST_FMO; end
            S_EXP_S:  exp_start = 1'b1;
            S_DW_S:   dw_start  = 1'b1;
            S_PRJ_S:  prj_start = 1'b1;
            default:  ;
        endcase
    end

    assign dma_op = w_dma_op;
    assign tile_x = r_tile_x;
    assign tile_y = r_tile_y;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign err    = r_err;

endmodule

// File: tb/tb_irb_tile_sequencer.sv
// Randomized bench for irb_tile_sequencer: behavioural responders, an event
// monitor and a tile-walk reference model built from the layer rules.
module tb_irb_tile_sequencer;

    localparam int TW  = 8;
    localparam int TOW = 8;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [TW-1:0] cfg_ntx, cfg_nty;
    logic          dma_req, dma_done;
    logic [1:0]    dma_op;
    logic          exp_start, exp_finish, dw_start, dw_finish, prj_start, prj_finish;
    logic [TW-1:0] tile_x, tile_y;
    logic          busy, done, err;

    wire [24:0] w_outs = {dma_req, dma_op, exp_start, dw_start, prj_start,
                          tile_x, tile_y, busy, done, err};

    irb_tile_sequencer #(.TILE_W(TW), .TIMEOUT_W(TOW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_ntx(cfg_ntx), .cfg_nty(cfg_nty),
        .dma_req(dma_req), .dma_op(dma_op), .dma_done(dma_done),
        .exp_start(exp_start), .exp_finish(exp_finish),
        .dw_start(dw_start), .dw_finish(dw_finish),
        .prj_start(prj_start), .prj_finish(prj_finish),
        .tile_x(tile_x), .tile_y(tile_y), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int lat_dma = 1, lat_exp = 1, lat_dw = 1, lat_prj = 1;
    bit prj_hold = 0;
    int inj_dw_n = 0;
    int exp_fin_cnt = 0, dw_fin_cnt = 0, prj_fin_cnt = 0;
    int ord_err = 0;
    int obs[$];
    int exp_q[$];

    // Event code: kind 1..3 = DMA op+1, 4 exp, 5 dw, 6 prj, 7 done; with tile coords.
    function automatic int ev(int k, int x, int y);
        return (k << 16) | (x << 8) | y;
    endfunction

    // Reference: weights once, then x-inner tile walk, each tile a fixed 5-step pipeline.
    function automatic void build_model(int nx, int ny);
        int ex, ey;
        ex = (nx == 0) ? 1 : nx;
        ey = (ny == 0) ? 1 : ny;
        exp_q.delete();
        exp_q.push_back(ev(1, 0, 0));
        for (int y = 0; y < ey; y++)
            for (int x = 0; x < ex; x++) begin
                exp_q.push_back(ev(2, x, y));
                exp_q.push_back(ev(4, x, y));
                exp_q.push_back(ev(5, x, y));
                exp_q.push_back(ev(6, x, y));
                exp_q.push_back(ev(3, x, y));
            end
        exp_q.push_back(ev(7, ex - 1, ey - 1));
    endfunction

    // Index of the first divergence between observed (from base) and expected, or -1.
    function automatic int first_diff(int base);
        int n, m;
        n = obs.size() - base;
        m = (n > exp_q.size()) ? n : exp_q.size();
        for (int i = 0; i < m; i++)
            if (i >= n || i >= exp_q.size() || obs[base + i] != exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int obs_at(int idx);
        return (idx < obs.size()) ? obs[idx] : -1;
    endfunction

    function automatic int exp_at(int idx);
        return (idx < exp_q.size()) ? exp_q[idx] : -1;
    endfunction

    // DMA responder: done pulse lat_dma cycles after a request is first seen.
    initial begin : dma_resp
        int cnt; bit pend;
        cnt = 0; pend = 0; dma_done = 0;
        forever begin
            @(negedge clk);
            dma_done = 0;
            if (rst || !dma_req) pend = 0;
            else begin
                if (!pend) begin pend = 1; cnt = lat_dma; end
                if (cnt == 0) begin dma_done = 1; pend = 0; end
                else cnt--;
            end
        end
    end

    // Expansion engine: finish lat_exp+1 cycles after the start pulse.
    initial begin : exp_resp
        int cnt; bit pend;
        cnt = 0; pend = 0; exp_finish = 0;
        forever begin
            @(negedge clk);
            exp_finish = 0;
            if (rst || !busy) pend = 0;
            else if (pend) begin
                if (cnt == 0) begin exp_finish = 1; pend = 0; exp_fin_cnt++; end
                else cnt--;
            end else if (exp_start) begin pend = 1; cnt = lat_exp; end
        end
    end

    // Depthwise engine, plus out-of-band dw_finish injection on request.
    initial begin : dw_resp
        int cnt, seen; bit pend;
        cnt = 0; seen = 0; pend = 0; dw_finish = 0;
        forever begin
            @(negedge clk);
            dw_finish = 0;
            if (rst || !busy) pend = 0;
            else if (pend) begin
                if (cnt == 0) begin dw_finish = 1; pend = 0; dw_fin_cnt++; end
                else cnt--;
            end else if (dw_start) begin pend = 1; cnt = lat_dw; end
            if (inj_dw_n != seen) begin dw_finish = 1; seen = inj_dw_n; end
        end
    end

    // Projection engine; prj_hold withholds the finish indefinitely.
    initial begin : prj_resp
        int cnt; bit pend;
        cnt = 0; pend = 0; prj_finish = 0;
        forever begin
            @(negedge clk);
            prj_finish = 0;
            if (rst || !busy) pend = 0;
            else if (pend) begin
                if (!prj_hold) begin
                    if (cnt == 0) begin prj_finish = 1; pend = 0; prj_fin_cnt++; end
                    else cnt--;
                end
            end else if (prj_start) begin pend = 1; cnt = lat_prj; end
        end
    end

    // Monitor: logs request/start/done events and flags a stage that starts before its predecessor finished.
    initial begin : mon
        logic p_req; logic [1:0] p_op; int ef_at, df_at, pf_at;
        p_req = 0; p_op = 0; ef_at = 0; df_at = 0; pf_at = 0;
        forever begin
            @(negedge clk);
            if (dma_req === 1'b1 && (!p_req || dma_op != p_op)) begin
                obs.push_back(ev(int'(dma_op) + 1, int'(tile_x), int'(tile_y)));
                if (dma_op == 2'd2 && prj_fin_cnt != pf_at + 1) ord_err++;
            end
            if (exp_start === 1'b1) begin
                obs.push_back(ev(4, int'(tile_x), int'(tile_y)));
                ef_at = exp_fin_cnt;
            end
            if (dw_start === 1'b1) begin
                obs.push_back(ev(5, int'(tile_x), int'(tile_y)));
                if (exp_fin_cnt != ef_at + 1) ord_err++;
                df_at = dw_fin_cnt;
            end
            if (prj_start === 1'b1) begin
                obs.push_back(ev(6, int'(tile_x), int'(tile_y)));
                if (dw_fin_cnt != df_at + 1) ord_err++;
                pf_at = prj_fin_cnt;
            end
            if (done === 1'b1) obs.push_back(ev(7, int'(tile_x), int'(tile_y)));
            p_req = (dma_req === 1'b1);
            p_op  = dma_op;
        end
    end

    task automatic kick(input int nx, input int ny);
        @(negedge clk);
        cfg_ntx = nx[TW-1:0];
        cfg_nty = ny[TW-1:0];
        start   = 1;
        @(negedge clk);
        start   = 0;
    endtask

    // Waits (bounded) for done or err; reports cycles where busy was low.
    task automatic wait_end(output bit gd, output int gap);
        gd = 0; gap = 0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin gd = 1; break; end
            if (err) break;
            if (!busy) gap++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; start = 0; cfg_ntx = 0; cfg_nty = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (w_outs !== 25'd0) begin n_fail++; $display("FAIL reset_hold outs=%h want 0", w_outs); end
        rst = 0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (w_outs !== 25'd0) begin n_fail++; $display("FAIL reset_idle outs=%h want 0", w_outs); end
    endtask

    task automatic test_2x2();
        int base, o0, fd, gap; bit gd;
        lat_dma = 3; lat_exp = 3; lat_dw = 3; lat_prj = 3;
        base = obs.size(); o0 = ord_err;
        kick(2, 2); wait_end(gd, gap); build_model(2, 2);
        n_tests++; if (gd !== 1'b1) begin n_fail++; $display("FAIL 2x2_done got=%0d want 1", gd); end
        fd = first_diff(base);
        n_tests++; if (fd != -1) begin n_fail++; $display("FAIL 2x2_events idx=%0d got=%h want=%h", fd, obs_at(base + fd), exp_at(fd)); end
        n_tests++; if (ord_err != o0) begin n_fail++; $display("FAIL 2x2_order got=%0d want=0", ord_err - o0); end
    endtask

    task automatic test_1x1_fast();
        int base, fd, gap, nd, nw; bit gd;
        lat_dma = 0; lat_exp = 0; lat_dw = 0; lat_prj = 0;
        base = obs.size();
        kick(1, 1); wait_end(gd, gap); repeat (4) @(negedge clk); build_model(1, 1);
        nd = 0; nw = 0;
        for (int i = base; i < obs.size(); i++) begin
            if (obs[i] >> 16 == 7) nd++;
            if (obs[i] >> 16 == 1) nw++;
        end
        n_tests++; if (nd != 1) begin n_fail++; $display("FAIL fast_done_count got=%0d want=1", nd); end
        n_tests++; if (nw != 1) begin n_fail++; $display("FAIL fast_ldw_count got=%0d want=1", nw); end
        n_tests++; if (gap != 0) begin n_fail++; $display("FAIL fast_busy_gap got=%0d want=0", gap); end
        fd = first_diff(base);
        n_tests++; if (fd != -1) begin n_fail++; $display("FAIL fast_events idx=%0d got=%h want=%h", fd, obs_at(base + fd), exp_at(fd)); end
    endtask

    task automatic test_ignore();
        int base, o0, fd, gap; bit gd;
        lat_dma = 1; lat_exp = 6; lat_dw = 1; lat_prj = 1;
        base = obs.size(); o0 = ord_err;
        kick(2, 1);
        for (int i = 0; i < 100 && !exp_start; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        cfg_ntx = 3; cfg_nty = 3; start = 1; inj_dw_n++;
        @(negedge clk);
        start = 0;
        wait_end(gd, gap); build_model(2, 1);
        n_tests++; if (gd !== 1'b1) begin n_fail++; $display("FAIL ignore_done got=%0d want 1", gd); end
        fd = first_diff(base);
        n_tests++; if (fd != -1) begin n_fail++; $display("FAIL ignore_events idx=%0d got=%h want=%h", fd, obs_at(base + fd), exp_at(fd)); end
        n_tests++; if (ord_err != o0) begin n_fail++; $display("FAIL ignore_order got=%0d want=0", ord_err - o0); end
    endtask

    task automatic test_timeout();
        int base, fd, gap, cyc; bit gd;
        lat_dma = 1; lat_exp = 1; lat_dw = 1; lat_prj = 1; prj_hold = 1;
        kick(1, 1);
        for (int i = 0; i < 200 && !prj_start; i++) @(negedge clk);
        cyc = 0;
        for (int i = 0; i < (1 << TOW) + 50; i++) begin
            @(negedge clk); cyc++;
            if (err) break;
        end
        // Counter clears entering PRJ_W, reaches all-ones after 2^W-1 increments,
        // that cycle steers to ERROR: err appears 2^W+1 cycles after the prj_start cycle.
        n_tests++; if (cyc != (1 << TOW) + 1) begin n_fail++; $display("FAIL timeout_latency got=%0d want=%0d", cyc, (1 << TOW) + 1); end
        n_tests++; if ({dma_req, exp_start, dw_start, prj_start} !== 4'b0) begin n_fail++; $display("FAIL timeout_quiet got=%b want=0000", {dma_req, exp_start, dw_start, prj_start}); end
        @(negedge clk);
        n_tests++; if ({busy, err} !== 2'b01) begin n_fail++; $display("FAIL timeout_idle busy,err=%b want=01", {busy, err}); end
        prj_hold = 0;
        base = obs.size();
        kick(1, 1);
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear got=%b want=0", err); end
        wait_end(gd, gap); build_model(1, 1);
        n_tests++; if (gd !== 1'b1) begin n_fail++; $display("FAIL timeout_rerun_done got=%0d want 1", gd); end
        fd = first_diff(base);
        n_tests++; if (fd != -1) begin n_fail++; $display("FAIL timeout_rerun_events idx=%0d got=%h want=%h", fd, obs_at(base + fd), exp_at(fd)); end
    endtask

    task automatic test_reset_mid();
        int base, fd, gap, nds; bit gd;
        lat_dma = 1; lat_exp = 1; lat_dw = 8; lat_prj = 1;
        kick(2, 1);
        nds = 0;
        for (int i = 0; i < 300 && nds < 2; i++) begin
            if (dw_start) nds++;
            if (nds < 2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        #3 rst = 1;
        #1;
        n_tests++; if (w_outs !== 25'd0) begin n_fail++; $display("FAIL midrst_async outs=%h want 0", w_outs); end
        repeat (2) @(negedge clk);
        rst = 0; inj_dw_n++;
        repeat (3) @(negedge clk);
        n_tests++; if (w_outs !== 25'd0) begin n_fail++; $display("FAIL midrst_late_finish outs=%h want 0", w_outs); end
        lat_dw = 1;
        base = obs.size();
        kick(1, 1); wait_end(gd, gap); build_model(1, 1);
        n_tests++; if (gd !== 1'b1) begin n_fail++; $display("FAIL midrst_rerun_done got=%0d want 1", gd); end
        fd = first_diff(base);
        n_tests++; if (fd != -1) begin n_fail++; $display("FAIL midrst_rerun_events idx=%0d got=%h want=%h", fd, obs_at(base + fd), exp_at(fd)); end
    endtask

    task automatic test_cfg_zero();
        int base, fd, gap; bit gd;
        lat_dma = 2; lat_exp = 0; lat_dw = 1; lat_prj = 2;
        base = obs.size();
        kick(0, 3); wait_end(gd, gap); build_model(0, 3);
        n_tests++; if (gd !== 1'b1) begin n_fail++; $display("FAIL cfgzero_done got=%0d want 1", gd); end
        fd = first_diff(base);
        n_tests++; if (fd != -1) begin n_fail++; $display("FAIL cfgzero_events idx=%0d got=%h want=%h", fd, obs_at(base + fd), exp_at(fd)); end
    endtask

    task automatic test_random();
        int base, o0, fd, gap, nx, ny; bit gd;
        for (int r = 0; r < 5; r++) begin
            nx = $urandom_range(0, 3); ny = $urandom_range(0, 3);
            lat_dma = $urandom_range(0, 4); lat_exp = $urandom_range(0, 4);
            lat_dw  = $urandom_range(0, 4); lat_prj = $urandom_range(0, 4);
            base = obs.size(); o0 = ord_err;
            kick(nx, ny); wait_end(gd, gap); build_model(nx, ny);
            n_tests++; if (gd !== 1'b1) begin n_fail++; $display("FAIL rand%0d_done got=%0d want 1", r, gd); end
            fd = first_diff(base);
            n_tests++; if (fd != -1) begin n_fail++; $display("FAIL rand%0d_events %0dx%0d idx=%0d got=%h want=%h", r, nx, ny, fd, obs_at(base + fd), exp_at(fd)); end
            n_tests++; if (ord_err != o0) begin n_fail++; $display("FAIL rand%0d_order got=%0d want=0", r, ord_err - o0); end
        end
    endtask

    initial begin
        test_reset();
        test_2x2();
        test_1x1_fast();
        test_ignore();
        test_timeout();
        test_reset_mid();
        test_cfg_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
